// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping engine: run/pause/lap FSM, centisecond prescaler and
// a six-digit BCD mm:ss.cc counter with a lap snapshot for the display.
module stopwatch_core #(
  parameter int TICK_DIV = 500000,
  parameter int PRE_W    = 19
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [3:0] g,
  output logic [3:0] h,
  output logic [3:0] i,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  // Digit 0 is centisecond units (i), digit 5 is minutes tens (d).
  localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0][3:0]  cnt_q, cnt_d, cnt_inc;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [5:0][3:0]  disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic             counting, tick, wrap, clear_hit, lap_enter;

  assign counting  = (state_q == RUN) || (state_q == LAP);
  assign tick      = counting && (pre_q == PRE_LAST);
  assign clear_hit = (state_q == PAUSE) && !start_stop && clear;
  assign lap_enter = (state_q == RUN) && !start_stop && lap;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
               else if (lap)   state_d = LAP;
      LAP:     if (start_stop) state_d = PAUSE;
               else if (lap)   state_d = RUN;
      PAUSE:   if (start_stop) state_d = RUN;
               else if (clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ripple-carry BCD increment; a carry out of the top digit is the overflow.
  always_comb begin
    logic carry;
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (carry) begin
        if (cnt_q[k] == DIGIT_MAX[k]) begin
          cnt_inc[k] = 4'd0;
        end else begin
          cnt_inc[k] = cnt_q[k] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    snap_d = snap_q;
    if (clear_hit) begin
      pre_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (counting) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        cnt_d = cnt_inc;
        ovf_d = ovf_q | wrap;
      end
    end
    // The snapshot captures the post-tick value so a coincident tick is not lost.
    if (lap_enter) snap_d = cnt_d;
    disp_d = (state_d == LAP) ? snap_d : cnt_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d          = disp_q[5];
  assign e          = disp_q[4];
  assign f          = disp_q[3];
  assign g          = disp_q[2];
  assign h          = disp_q[1];
  assign i          = disp_q[0];
  assign running    = counting;
  assign lap_active = (state_q == LAP);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus random button
// traffic, compared each cycle against an integer-centisecond reference model.
module tb_stopwatch_core;

  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;
  localparam int WRAP_CS  = 360000;

  logic        clk        = 1'b0;
  logic        hard_reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap        = 1'b0;
  logic        clear      = 1'b0;
  logic [3:0]  d, e, f, g, h, i;
  logic        running, lap_active, ovf;
  logic [23:0] shown;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_LAP} mode_e;
  mode_e m_mode;
  int    m_cs, m_frac, m_snap;
  bit    m_ovf;

  always #5 clk = ~clk;

  stopwatch_core #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .d          (d),
    .e          (e),
    .f          (f),
    .g          (g),
    .h          (h),
    .i          (i),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  assign shown = {d, e, f, g, h, i};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cs   = 0;
    m_frac = 0;
    m_snap = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the reference: time advances first, then buttons act.
  task automatic model_edge(input bit ss, input bit lp, input bit cl);
    if (m_mode == M_RUN || m_mode == M_LAP) begin
      m_frac++;
      if (m_frac == TICK_DIV) begin
        m_frac = 0;
        m_cs++;
        if (m_cs == WRAP_CS) begin
          m_cs  = 0;
          m_ovf = 1'b1;
        end
      end
    end
    case (m_mode)
      M_IDLE:  if (ss) m_mode = M_RUN;
      M_RUN:   if (ss) m_mode = M_PAUSE;
               else if (lp) begin m_mode = M_LAP; m_snap = m_cs; end
      M_LAP:   if (ss) m_mode = M_PAUSE;
               else if (lp) m_mode = M_RUN;
      M_PAUSE: if (ss) m_mode = M_RUN;
               else if (cl) begin m_mode = M_IDLE; m_cs = 0; m_frac = 0; m_ovf = 1'b0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_model();
    check("digits", shown, to_bcd(m_mode == M_LAP ? m_snap : m_cs));
    check("running", running, (m_mode == M_RUN) || (m_mode == M_LAP));
    check("lap_active", lap_active, m_mode == M_LAP);
    check("ovf", ovf, m_ovf);
  endtask

  // Called at a falling edge: drive pulses, take one rising edge, check.
  task automatic cycle(input bit ss = 1'b0, input bit lp = 1'b0, input bit cl = 1'b0);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    @(posedge clk);
    model_edge(ss, lp, cl);
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, shown, 24'h000000);
    check({tag, "_running"}, running, 1'b0);
    check({tag, "_lap"}, lap_active, 1'b0);
    check({tag, "_ovf"}, ovf, 1'b0);
  endtask

  task automatic do_reset();
    hard_reset = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (3) @(negedge clk);
    model_reset();
    check_model();
    hard_reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Reset, then idle with ignored lap/clear pulses.
    do_reset();
    for (int n = 0; n < 20; n++) cycle(1'b0, n[0], n[1]);
    check_zero("idle");

    // Basic count: 123 ticks.
    do_reset();
    cycle(1'b1);
    repeat (4 * 123) cycle();
    check("basic_count", shown, 24'h000123);
    check("basic_running", running, 1'b1);

    // Pause holds digits and the fractional centisecond.
    do_reset();
    cycle(1'b1);
    repeat (6) cycle();
    cycle(1'b1);
    repeat (50) cycle();
    check("pause_hold", shown, 24'h000001);
    check("pause_running", running, 1'b0);
    cycle(1'b1);
    cycle();
    check("resume_frac", shown, 24'h000002);

    // Lap freeze and release.
    do_reset();
    cycle(1'b1);
    for (int n = 0; n < 64 && m_cs != 5; n++) cycle();
    check("lap_at_05", shown, 24'h000005);
    cycle(1'b0, 1'b1);
    repeat (40) cycle();
    check("lap_frozen", shown, 24'h000005);
    check("lap_flag", lap_active, 1'b1);
    cycle(1'b0, 1'b1);
    check("lap_exit_live", shown, to_bcd(m_cs));
    check("lap_exit_flag", lap_active, 1'b0);

    // Overflow from 59:59.99, then clear from PAUSE.
    do_reset();
    cycle(1'b1);
    repeat (3) cycle();
    cycle(1'b1);
    force dut.cnt_q = 24'h595999;
    m_cs = WRAP_CS - 1;
    cycle();
    release dut.cnt_q;
    check("preload", shown, 24'h595999);
    cycle(1'b1);
    for (int n = 0; n < 2 * TICK_DIV && !m_ovf; n++) cycle();
    check("ovf_digits", shown, 24'h000000);
    check("ovf_set", ovf, 1'b1);
    repeat (5) cycle();
    check("ovf_sticky", ovf, 1'b1);
    cycle(1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check_zero("clear");

    // Priority and ignored pulses.
    do_reset();
    cycle(1'b1);
    repeat (9) cycle();
    cycle(1'b1, 1'b1);
    check("ss_lap_lapflag", lap_active, 1'b0);
    check("ss_lap_running", running, 1'b0);
    cycle(1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    repeat (6) cycle();
    check("clr_in_run", running, 1'b1);
    cycle(1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check("ss_clr_running", running, 1'b1);
    check("ss_clr_digits", shown, to_bcd(m_cs));

    // Random button traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset in the middle of a lap.
    do_reset();
    cycle(1'b1);
    repeat (7) cycle();
    cycle(1'b0, 1'b1);
    repeat (9) cycle();
    check("pre_rst_lap", lap_active, 1'b1);
    @(posedge clk);
    #2;
    hard_reset = 1'b0;
    #1;
    check_zero("mid_lap_rst");
    @(negedge clk);
    model_reset();
    hard_reset = 1'b1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Timekeeping engine of the stopwatch. Produces the six BCD digits (mm:ss.cc) that the display multiplexer scans onto the 7-segment panel.
- Consumes one-cycle, already-debounced button pulses (start/stop, lap, clear).
- Runs a run/pause/lap state machine and a centisecond prescaler.
- Outputs are registered BCD nibbles, wired straight to the display controller digit inputs d..i (d most significant).

Parameters:
- TICK_DIV, 500000, clk cycles per centisecond (50 MHz clock); legal range >= 2.
- PRE_W, 19, prescaler width; must satisfy 2^PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock
- hard_reset  in  1  asynchronous, active-low reset (0 = reset)
- start_stop  in  1  one-cycle pulse: start or stop counting
- lap  in  1  one-cycle pulse: freeze or unfreeze the displayed value
- clear  in  1  one-cycle pulse: zero the time (honoured only in PAUSE)
- d  out  4  minutes tens (0-5)
- e  out  4  minutes units (0-9)
- f  out  4  seconds tens (0-5)
- g  out  4  seconds units (0-9)
- h  out  4  centiseconds tens (0-9)
- i  out  4  centiseconds units (0-9)
- running  out  1  high in RUN and LAP
- lap_active  out  1  high in LAP (display frozen)
- ovf  out  1  sticky: time wrapped past 59:59.99

Behaviour:
- Reset (hard_reset=0, async assert, sync release):
  - state=IDLE; prescaler=0; all counter digits=0; snapshot=0.
  - d..i=0; running=0; lap_active=0; ovf=0.
- States: IDLE, RUN, PAUSE, LAP. Transitions are evaluated on the rising clk edge.
  - IDLE: start_stop -> RUN. lap and clear are ignored.
  - RUN: start_stop -> PAUSE; otherwise lap -> LAP. clear is ignored.
  - LAP: start_stop -> PAUSE (display returns live); otherwise lap -> RUN (display returns live). clear is ignored.
  - PAUSE: start_stop -> RUN; otherwise clear -> IDLE. lap is ignored.
- Priority on simultaneous pulses: start_stop > lap > clear.
- Prescaler:
  - Increments every cycle in RUN and LAP.
  - At TICK_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - Holds its value in PAUSE, so the fractional centisecond is preserved.
  - Zeroed on entry to IDLE.
- Digit chain, ripple-carry BCD, advanced on tick:
  - i 9->0 carries to h.
  - h 9->0 carries to g.
  - g 9->0 carries to f.
  - f 5->0 carries to e.
  - e 9->0 carries to d.
  - d 5->0 is the overflow: all digits read 00:00.00 and ovf is set. ovf stays high until clear or reset.
  - All digits update on the same edge as tick. No digit ever shows an illegal BCD value (f, d > 5; others > 9).
- Display source:
  - In IDLE, RUN and PAUSE, d..i follow the live counter registers with zero added latency; a change is visible after the tick edge.
  - On the edge that enters LAP, the snapshot loads the counter's next value, including any increment from a coincident tick.
  - While in LAP, d..i show the snapshot and the live counter keeps running underneath.
  - On leaving LAP, d..i switch back to live on the next edge.
- Clear (honoured only in PAUSE):
  - On the same edge: counter digits=0, prescaler=0, ovf=0; state becomes IDLE.
  - running=0 and lap_active=0 follow from the state.
- Reset asserted mid-count or mid-lap: immediate return to the reset values above, without waiting for a clock edge.

Test Plan (TICK_DIV=4):
- Reset then idle: hold hard_reset=0 for 3 cycles, release, wait 20 cycles -> d..i all 0, running=0, lap_active=0, ovf=0.
- Basic count: start_stop pulse, run 4*123 cycles -> d..i = 0,0,0,1,2,3 (00:01.23), running=1.
- Pause/resume preserving the fraction:
  - Start, run 6 cycles, pulse start_stop, wait 50 cycles -> digits frozen at 00:00.01 and the prescaler holds.
  - Resume -> the next tick arrives 2 cycles later, not 4.
- Lap freeze:
  - Start, at 00:00.05 pulse lap, run 40 more cycles -> d..i stay 00:00.05 and lap_active=1.
  - Pulse lap -> next edge shows 00:00.15.
- Overflow and clear:
  - Preload to 59:59.99 by forcing the counter, then 1 tick -> 00:00.00 with ovf=1.
  - Pulse start_stop, then clear -> state IDLE, ovf=0, digits 0.
- Priority and ignores:
  - start_stop+lap together in RUN -> PAUSE, lap_active=0.
  - clear in RUN -> ignored, count continues.
  - start_stop+clear together in PAUSE -> RUN with digits intact.
  - Assert hard_reset mid-LAP -> all outputs 0 asynchronously.
